alu_issue_stage: RTL and testbench

- Decode/issue pipeline stage that produces the operand and opcode interface consumed by the stage-2 ALU.
- Takes a fetched RV32I instruction plus PC and register-file read data.
- Decodes the ALU operation and immediates, selects operands A/B, and registers them behind a valid/ready handshake toward execute.
- Absorbs execute back-pressure and supports pipeline flush.

---
 rtl/alu_issue_stage_pkg.sv | 93 +++++++++
 rtl/alu_issue_stage_decode.sv | 86 ++++++++
 rtl/alu_issue_stage.sv | 102 ++++++++++
 tb/tb_alu_issue_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared ALUop encodings, RV32I opcode/funct constants and issue-entry type for alu_issue_stage.
package alu_issue_stage_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_COPY_B = 4'd10,
        ALU_XXX    = 4'd15
    } alu_op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_U = 2'd2
    } imm_sel_e;

    typedef struct packed {
        logic [ALU_W-1:0] alu_a;
        logic [ALU_W-1:0] alu_b;
        alu_op_e          alu_op;
        logic [4:0]       rd;
        logic             rd_we;
        logic             illegal;
    } issue_t;

    localparam issue_t ISSUE_RESET = '{
        alu_a:   '0,
        alu_b:   '0,
        alu_op:  ALU_XXX,
        rd:      5'd0,
        rd_we:   1'b0,
        illegal: 1'b0
    };

    function automatic logic [ALU_W-1:0] imm_gen(input logic [31:0] inst, input imm_sel_e sel);
        logic [ALU_W-1:0] imm;
        case (sel)
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_U:   imm = {inst[31:12], 12'b0};
            default: imm = {{20{inst[31]}}, inst[31:20]};
        endcase
        return imm;
    endfunction

    // inst[30] only picks SUB on register-register ops; on OP-IMM bit 30 belongs to the immediate.
    function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt, input logic is_reg);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Combinational RV32I decode: instruction, PC and register data to ALU operands/op and writeback info.
module alu_issue_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output issue_t      o_entry
);

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic       w_alt;
    logic [4:0] w_rd;
    logic       w_is_shift;
    logic       w_we;

    assign w_opcode   = i_inst[6:0];
    assign w_f3       = i_inst[14:12];
    assign w_alt      = i_inst[30];
    assign w_rd       = i_inst[11:7];
    assign w_is_shift = (w_f3 == F3_SLL) || (w_f3 == F3_SR);

    always_comb begin
        o_entry         = ISSUE_RESET;
        o_entry.rd      = w_rd;
        o_entry.illegal = 1'b0;
        w_we            = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                o_entry.alu_op = ALU_COPY_B;
                o_entry.alu_b  = imm_gen(i_inst, IMM_U);
                w_we           = 1'b1;
            end
            OPC_AUIPC: begin
                o_entry.alu_op = ALU_ADD;
                o_entry.alu_a  = i_pc;
                o_entry.alu_b  = imm_gen(i_inst, IMM_U);
                w_we           = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                o_entry.alu_op = ALU_ADD;
                o_entry.alu_a  = i_pc;
                o_entry.alu_b  = 32'd4;
                w_we           = 1'b1;
            end
            OPC_LOAD: begin
                o_entry.alu_op = ALU_ADD;
                o_entry.alu_a  = i_rs1;
                o_entry.alu_b  = imm_gen(i_inst, IMM_I);
                w_we           = 1'b1;
            end
            OPC_STORE: begin
                o_entry.alu_op = ALU_ADD;
                o_entry.alu_a  = i_rs1;
                o_entry.alu_b  = imm_gen(i_inst, IMM_S);
            end
            OPC_BRANCH: begin
                o_entry.alu_op = ALU_SUB;
                o_entry.alu_a  = i_rs1;
                o_entry.alu_b  = i_rs2;
            end
            OPC_OP_IMM: begin
                o_entry.alu_op = f3_to_op(w_f3, w_alt, 1'b0);
                o_entry.alu_a  = i_rs1;
                o_entry.alu_b  = w_is_shift ? {27'b0, i_inst[24:20]} : imm_gen(i_inst, IMM_I);
                w_we           = 1'b1;
            end
            OPC_OP: begin
                if (w_alt && !w_is_shift && (w_f3 != F3_ADD)) begin
                    o_entry.illegal = 1'b1;
                end else begin
                    o_entry.alu_op = f3_to_op(w_f3, w_alt, 1'b1);
                    o_entry.alu_a  = i_rs1;
                    o_entry.alu_b  = i_rs2;
                    w_we           = 1'b1;
                end
            end
            default: o_entry.illegal = 1'b1;
        endcase
        // x0 is hardwired to zero, so writes to it are dropped here rather than in writeback.
        o_entry.rd_we = w_we && (w_rd != 5'd0);
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue register and valid/ready handshake toward execute.
// Define ALU_ISSUE_SKID_EN to add a skid entry that makes in_ready a registered signal.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_alu_a,
    output logic [XLEN-1:0] out_alu_b,
    output logic [3:0]      out_alu_op,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_illegal
);

    issue_t w_dec;
    issue_t r_out;
    logic   r_out_valid;
    logic   w_in_xfer;

    alu_issue_decode u_decode (
        .i_inst  (in_inst),
        .i_pc    (in_pc),
        .i_rs1   (in_rs1),
        .i_rs2   (in_rs2),
        .o_entry (w_dec)
    );

    assign w_in_xfer   = in_valid && in_ready;
    assign out_valid   = r_out_valid;
    assign out_alu_a   = r_out.alu_a;
    assign out_alu_b   = r_out.alu_b;
    assign out_alu_op  = r_out.alu_op;
    assign out_rd      = r_out.rd;
    assign out_rd_we   = r_out.rd_we;
    assign out_illegal = r_out.illegal;

`ifdef ALU_ISSUE_SKID_EN
    issue_t r_skid;
    logic   r_skid_valid;

    assign in_ready = !r_skid_valid;

    // Skid only fills while the output is full and stalled, so it always drains first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out        <= ISSUE_RESET;
            r_skid_valid <= 1'b0;
            r_skid       <= ISSUE_RESET;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= w_in_xfer;
                if (w_in_xfer) begin
                    r_skid <= w_dec;
                end
            end else begin
                r_out_valid <= w_in_xfer;
                if (w_in_xfer) begin
                    r_out <= w_dec;
                end
            end
        end else if (w_in_xfer) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready = !r_out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out       <= ISSUE_RESET;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out       <= w_dec;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed scoreboard bench for alu_issue_stage; follows ALU_ISSUE_SKID_EN when it is defined.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu_a;
    logic [31:0] out_alu_b;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_alu_a   (out_alu_a),
        .out_alu_b   (out_alu_b),
        .out_alu_op  (out_alu_op),
        .out_rd      (out_rd),
        .out_rd_we   (out_rd_we),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                input logic [4:0] rd, input logic we, input logic ill);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.rd = rd; e.we = we; e.ill = ill;
        return e;
    endfunction

    // Output-side scoreboard: every accepted output must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", {31'b0, out_valid}, 32'd0);
            end else begin
                cur = q.pop_front();
                chk("out_op", {28'b0, out_alu_op}, {28'b0, cur.op});
                chk("out_rd", {27'b0, out_rd}, {27'b0, cur.rd});
                chk("out_rd_we", {31'b0, out_rd_we}, {31'b0, cur.we});
                chk("out_illegal", {31'b0, out_illegal}, {31'b0, cur.ill});
                if (!cur.ill) begin
                    chk("out_alu_a", out_alu_a, cur.a);
                    chk("out_alu_b", out_alu_b, cur.b);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        in_rs1   = rs1;
        in_rs2   = rs2;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input exp_t e);
        int n;
        drive(inst, pc, rs1, rs2);
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!in_ready) chk("accept_timeout", {31'b0, in_ready}, 32'd1);
        else q.push_back(e);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", q.size(), 32'd0);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_a"}, out_alu_a, 32'd0);
        chk({tag, "_b"}, out_alu_b, 32'd0);
        chk({tag, "_op"}, {28'b0, out_alu_op}, {28'b0, ALU_XXX});
        chk({tag, "_rd"}, {27'b0, out_rd}, 32'd0);
        chk({tag, "_rd_we"}, {31'b0, out_rd_we}, 32'd0);
        chk({tag, "_illegal"}, {31'b0, out_illegal}, 32'd0);
    endtask

    localparam logic [31:0] I_ADDI = 32'hFFD08293;  // addi x5,x1,-3

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        #12;
        check_reset_outputs("reset");
        step();
        reset = 1'b0;
        #1;
        chk("in_ready_after_reset", {31'b0, in_ready}, 32'd1);
        step();

        // Decode coverage with execute always ready.
        out_ready = 1'b1;
        send(I_ADDI, 32'h100, 32'd10, 32'd0, mk(32'd10, 32'hFFFFFFFD, ALU_ADD, 5'd5, 1'b1, 1'b0));
        chk("latency_valid", {31'b0, out_valid}, 32'd1);
        send(32'h40415193, 32'h104, 32'h8000_0000, 32'd7, mk(32'h8000_0000, 32'd4, ALU_SRA, 5'd3, 1'b1, 1'b0));
        send(32'h00415193, 32'h108, 32'h0000_00F0, 32'd7, mk(32'h0000_00F0, 32'd4, ALU_SRL, 5'd3, 1'b1, 1'b0));
        send(32'h403100B3, 32'h10C, 32'd50, 32'd8, mk(32'd50, 32'd8, ALU_SUB, 5'd1, 1'b1, 1'b0));
        send(32'h123453B7, 32'h110, 32'h55, 32'h66, mk(32'd0, 32'h12345000, ALU_COPY_B, 5'd7, 1'b1, 1'b0));
        send(32'h80000117, 32'h200, 32'h1, 32'h2, mk(32'h200, 32'h80000000, ALU_ADD, 5'd2, 1'b1, 1'b0));
        send(32'h008000EF, 32'h300, 32'h1, 32'h2, mk(32'h300, 32'd4, ALU_ADD, 5'd1, 1'b1, 1'b0));
        send(32'hFE20AE23, 32'h304, 32'h1000, 32'h2, mk(32'h1000, 32'hFFFFFFFC, ALU_ADD, 5'd28, 1'b0, 1'b0));
        send(32'h00208463, 32'h308, 32'd9, 32'd4, mk(32'd9, 32'd4, ALU_SUB, 5'd8, 1'b0, 1'b0));
        send(32'h0000007F, 32'h30C, 32'd9, 32'd4, mk(32'd0, 32'd0, ALU_XXX, 5'd0, 1'b0, 1'b1));
        send(32'h00208033, 32'h310, 32'd9, 32'd4, mk(32'd9, 32'd4, ALU_ADD, 5'd0, 1'b0, 1'b0));
        send(32'h0010B213, 32'h314, 32'd3, 32'd4, mk(32'd3, 32'd1, ALU_SLTU, 5'd4, 1'b1, 1'b0));
        send(32'h4020E333, 32'h318, 32'd3, 32'd4, mk(32'd0, 32'd0, ALU_XXX, 5'd6, 1'b0, 1'b1));
        send(32'h0100A483, 32'h31C, 32'h400, 32'd4, mk(32'h400, 32'd16, ALU_ADD, 5'd9, 1'b1, 1'b0));
        drain();

        // Back-pressure: three back-to-back instructions against a stalled execute.
        step();
        out_ready = 1'b0;
        drive(I_ADDI, 32'h0, 32'h11, 32'h0);
        #1;
        chk("bp_first_ready", {31'b0, in_ready}, 32'd1);
        q.push_back(mk(32'h11, 32'hFFFFFFFD, ALU_ADD, 5'd5, 1'b1, 1'b0));
        step();
        drive(I_ADDI, 32'h0, 32'h22, 32'h0);
        #1;
`ifdef ALU_ISSUE_SKID_EN
        chk("bp_skid_ready", {31'b0, in_ready}, 32'd1);
        q.push_back(mk(32'h22, 32'hFFFFFFFD, ALU_ADD, 5'd5, 1'b1, 1'b0));
        step();
        drive(I_ADDI, 32'h0, 32'h33, 32'h0);
        #1;
        chk("bp_skid_full_ready", {31'b0, in_ready}, 32'd0);
`else
        chk("bp_full_ready", {31'b0, in_ready}, 32'd0);
`endif
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #2;
            chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_hold_a", out_alu_a, 32'h11);
            chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
`ifndef ALU_ISSUE_SKID_EN
        send(I_ADDI, 32'h0, 32'h22, 32'h0, mk(32'h22, 32'hFFFFFFFD, ALU_ADD, 5'd5, 1'b1, 1'b0));
`endif
        send(I_ADDI, 32'h0, 32'h33, 32'h0, mk(32'h33, 32'hFFFFFFFD, ALU_ADD, 5'd5, 1'b1, 1'b0));
        drain();

        // Flush with the output (and skid, when present) full and an input offered.
        step();
        out_ready = 1'b0;
        drive(I_ADDI, 32'h0, 32'h44, 32'h0);
        step();
        drive(I_ADDI, 32'h0, 32'h55, 32'h0);
        step();
        drive(I_ADDI, 32'h0, 32'h66, 32'h0);
        flush = 1'b1;
        #1;
        chk("flush_pre_valid", {31'b0, out_valid}, 32'd1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);

        // Flush while empty: the accepted input must be discarded.
        out_ready = 1'b1;
        drive(I_ADDI, 32'h0, 32'h77, 32'h0);
        flush = 1'b1;
        #1;
        chk("flush2_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush2_valid", {31'b0, out_valid}, 32'd0);
        repeat (3) step();
        send(32'h0100A483, 32'h40, 32'h800, 32'd0, mk(32'h800, 32'd16, ALU_ADD, 5'd9, 1'b1, 1'b0));
        drain();

        // Asynchronous reset in the middle of a stall.
        step();
        out_ready = 1'b0;
        drive(32'h403100B3, 32'h0, 32'd5, 32'd3);
        step();
        in_valid = 1'b0;
        #1;
        chk("stall_valid", {31'b0, out_valid}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        step();
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("post_reset_valid", {31'b0, out_valid}, 32'd0);

        out_ready = 1'b1;
        send(32'h403100B3, 32'h0, 32'd5, 32'd3, mk(32'd5, 32'd3, ALU_SUB, 5'd1, 1'b1, 1'b0));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
